// File: rtl/wb_stream_reader_fifo.sv
// Packs a narrow valid/ready beat stream little-endian into WB_DW words and
// buffers them in a first-word-fall-through FIFO for the burst-write controller.
module wb_stream_reader_fifo #(
  parameter int WB_DW   = 32,
  parameter int IW      = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [IW-1:0]      stream_s_data_i,
  input  logic               stream_s_valid_i,
  output logic               stream_s_ready_o,
  input  logic               stream_s_last_i,
  output logic [WB_DW-1:0]   fifo_d,
  input  logic               fifo_rd,
  output logic [FIFO_AW:0]   fifo_cnt,
  input  logic               clear,
  output logic               underflow
);

  localparam int R     = WB_DW / IW;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = (R > 1) ? $clog2(R) : 1;

  localparam logic [LW-1:0]      LANE_MAX  = LW'(R - 1);
  localparam logic [LW-1:0]      LANE_ZERO = LW'(0);
  localparam logic [LW-1:0]      LANE_ONE  = LW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ZERO  = FIFO_AW'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ZERO  = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [WB_DW-1:0]   WORD_ZERO = WB_DW'(0);

  logic [WB_DW-1:0]   mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   cnt_r;
  logic [LW-1:0]      lane_r;
  logic [WB_DW-1:0]   part_r;
  logic               underflow_r;

  logic               ready_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic [WB_DW-1:0]   word_s;

  // Ready looks only at the registered count so it never combinationally follows fifo_rd.
  assign ready_s          = !wb_rst_i && !clear && (cnt_r != CNT_FULL);
  assign accept_s         = stream_s_valid_i && ready_s;
  assign push_s           = accept_s && ((lane_r == LANE_MAX) || stream_s_last_i);
  assign pop_s            = fifo_rd && !clear && (cnt_r != CNT_ZERO);

  assign stream_s_ready_o = ready_s;
  assign fifo_d           = mem_r[rd_ptr_r];
  assign fifo_cnt         = cnt_r;
  assign underflow        = underflow_r;

  // Merge the incoming beat into the lanes gathered so far.
  always_comb begin
    word_s = part_r;
    word_s[lane_r*IW +: IW] = stream_s_data_i;
  end

  // FIFO storage; contents need no reset since the count qualifies them.
  always_ff @(posedge wb_clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // Pointers, occupancy, packer lane state and sticky underflow.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      cnt_r       <= CNT_ZERO;
      lane_r      <= LANE_ZERO;
      part_r      <= WORD_ZERO;
      underflow_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      cnt_r       <= CNT_ZERO;
      lane_r      <= LANE_ZERO;
      part_r      <= WORD_ZERO;
      underflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
      // The partial word is only cleared by a push, so a stall at full keeps it intact.
      if (push_s) begin
        lane_r <= LANE_ZERO;
        part_r <= WORD_ZERO;
      end else if (accept_s) begin
        lane_r <= lane_r + LANE_ONE;
        part_r <= word_s;
      end
      if (fifo_rd && (cnt_r == CNT_ZERO)) begin
        underflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_stream_reader_fifo.sv
// Randomized and directed bench for wb_stream_reader_fifo against a queue-based
// model of the packer and FIFO.
module tb_wb_stream_reader_fifo;

  localparam int WB_DW   = 32;
  localparam int IW      = 16;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;
  localparam int R       = WB_DW / IW;

  logic               wb_clk_i = 1'b0;
  logic               wb_rst_i = 1'b1;
  logic [IW-1:0]      stream_s_data_i = '0;
  logic               stream_s_valid_i = 1'b0;
  logic               stream_s_ready_o;
  logic               stream_s_last_i = 1'b0;
  logic [WB_DW-1:0]   fifo_d;
  logic               fifo_rd = 1'b0;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               clear = 1'b0;
  logic               underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [WB_DW-1:0] fifo_q [$];
  logic [IW-1:0]    pend_q [$];
  logic             uf_m = 1'b0;

  wb_stream_reader_fifo #(.WB_DW(WB_DW), .IW(IW), .FIFO_AW(FIFO_AW)) dut (
    .wb_clk_i         (wb_clk_i),
    .wb_rst_i         (wb_rst_i),
    .stream_s_data_i  (stream_s_data_i),
    .stream_s_valid_i (stream_s_valid_i),
    .stream_s_ready_o (stream_s_ready_o),
    .stream_s_last_i  (stream_s_last_i),
    .fifo_d           (fifo_d),
    .fifo_rd          (fifo_rd),
    .fifo_cnt         (fifo_cnt),
    .clear            (clear),
    .underflow        (underflow)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    pend_q.delete();
    uf_m = 1'b0;
  endtask

  // One clock cycle: drive, check ready, advance model across the edge, check state.
  task automatic step(input logic v, input logic [IW-1:0] d, input logic l,
                      input logic rd, input logic clr);
    logic             exp_rdy;
    logic [WB_DW-1:0] w;
    stream_s_valid_i = v;
    stream_s_data_i  = d;
    stream_s_last_i  = l;
    fifo_rd          = rd;
    clear            = clr;
    #1;
    exp_rdy = !clr && (fifo_q.size() != DEPTH);
    chk("ready", 32'(stream_s_ready_o), 32'(exp_rdy));
    @(posedge wb_clk_i);
    if (clr) begin
      model_reset();
    end else begin
      if (rd && fifo_q.size() == 0) uf_m = 1'b1;
      if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (v && exp_rdy) begin
        pend_q.push_back(d);
        if (l || pend_q.size() == R) begin
          w = '0;
          foreach (pend_q[i]) w = w | ({16'd0, pend_q[i]} << (IW * i));
          fifo_q.push_back(w);
          pend_q.delete();
        end
      end
    end
    #1;
    chk("cnt", 32'(fifo_cnt), 32'(fifo_q.size()));
    chk("underflow", 32'(underflow), 32'(uf_m));
    if (fifo_q.size() != 0) chk("fifo_d", fifo_d, fifo_q[0]);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_ready", 32'(stream_s_ready_o), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;

    // Two beats pack into one word, visible only after the second accept
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    chk("t1_cnt_early", 32'(fifo_cnt), 32'd0);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    chk("t1_word", fifo_d, 32'h22221111);
    chk("t1_cnt", 32'(fifo_cnt), 32'd1);

    // Last-terminated partial word, then a normal pair
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0);
    chk("t2_partial", fifo_d, 32'h0000ABCD);
    chk("t2_cnt", 32'(fifo_cnt), 32'd1);
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
    chk("t2_second", fifo_d, 32'h00020001);

    // Fill to full, then pop one while holding a beat
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    chk("t3_full_cnt", 32'(fifo_cnt), 32'd16);
    chk("t3_ready_low", 32'(stream_s_ready_o), 32'd0);
    chk("t3_head", fifo_d, 32'h00010000);
    step(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
    chk("t3_cnt_after_pop", 32'(fifo_cnt), 32'd15);
    chk("t3_ready_back", 32'(stream_s_ready_o), 32'd1);
    chk("t3_next_head", fifo_d, 32'h00030002);
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
    chk("t3_refull", 32'(fifo_cnt), 32'd16);

    // Simultaneous push and pop keeps the count
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0);
    chk("t4_cnt_hold", 32'(fifo_cnt), 32'd5);

    // Underflow is sticky until clear
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("t5_uf_set", 32'(underflow), 32'd1);
    chk("t5_cnt", 32'(fifo_cnt), 32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t5_uf_hold", 32'(underflow), 32'd1);
    step(1'b1, 16'h9999, 1'b0, 1'b0, 1'b1);
    chk("t5_uf_clear", 32'(underflow), 32'd0);

    // Asynchronous reset mid-cycle with a lane pending
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
    stream_s_valid_i = 1'b0;
    #3;
    wb_rst_i = 1'b1;
    #1;
    chk("t6_cnt", 32'(fifo_cnt), 32'd0);
    chk("t6_ready", 32'(stream_s_ready_o), 32'd0);
    model_reset();
    #2;
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
    chk("t6_word", fifo_d, 32'h44443333);

    // Random traffic across many pointer wraps
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 4) != 0, 16'($urandom), ($urandom % 8) == 0,
           ($urandom % 3) == 0, ($urandom % 150) == 0);
    end
    for (int k = 0; k < 64 && fifo_q.size() != 0; k++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(fifo_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_stream_reader_fifo.md
Name: wb_stream_reader_fifo

Overview:
- Upstream feeder for the Wishbone stream-to-memory burst-write controller.
- Accepts a narrow valid/ready pixel stream and packs beats little-endian into WB_DW words.
- Buffers packed words in a first-word-fall-through FIFO.
- Presents the fifo_d / fifo_rd / fifo_cnt interface that the burst controller consumes. The controller reads fifo_d combinationally and pops with its Wishbone ack.

Parameters:
- WB_DW, 32: FIFO word width, equal to the Wishbone data width.
- IW, 16: input stream beat width. WB_DW must be an integer multiple of IW. R = WB_DW/IW lanes per word.
- FIFO_AW, 4: FIFO address width. DEPTH = 2^FIFO_AW words.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- stream_s_data_i  in  IW  input beat.
- stream_s_valid_i  in  1  beat valid.
- stream_s_ready_o  out  1  block can accept a beat.
- stream_s_last_i  in  1  final beat of a frame; forces a partial word to be pushed.
- fifo_d  out  WB_DW  head-of-FIFO word, valid while fifo_cnt>0.
- fifo_rd  in  1  pop head word this cycle.
- fifo_cnt  out  FIFO_AW+1  words currently stored, range 0..DEPTH.
- clear  in  1  synchronous flush of FIFO and packer.
- underflow  out  1  sticky: fifo_rd was seen while the FIFO was empty.

Behaviour:
- Reset (async, immediate):
  - Read/write pointers, fifo_cnt, lane index and partial-word register all go to 0.
  - underflow=0.
  - stream_s_ready_o=0 while wb_rst_i is high.
  - fifo_d is don't-care while empty.
- Accept: a beat is accepted when stream_s_valid_i & stream_s_ready_o.
- Ready: stream_s_ready_o = !wb_rst_i & !clear & (fifo_cnt != DEPTH). It is combinational from registered count and never depends on fifo_rd.
- Packing:
  - An accepted beat at lane k is written to bits [k*IW +: IW] of the word being assembled. The lane then increments.
  - A word completes when the accepted beat is at lane R-1, or stream_s_last_i=1.
  - On completion, the word (current beat merged with previously stored lanes) is written to mem[wr_ptr] on that edge, wr_ptr increments, and the lane returns to 0.
  - In a last-terminated partial word, unfilled upper lanes are zero. The partial register clears after every push.
  - R=1: every accepted beat is pushed directly.
- Push-to-visible latency: fifo_cnt and fifo_d reflect the pushed word on the cycle after the accepting edge.
- Pop:
  - A pop occurs when fifo_rd & (fifo_cnt != 0). rd_ptr increments and the next word appears on fifo_d the following cycle.
  - fifo_d = mem[rd_ptr], read asynchronously (distributed RAM, FWFT).
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop on the same edge: unchanged. Data order is preserved; when fifo_cnt was 0 the push cannot be popped the same cycle.
- Pointers are FIFO_AW bits and wrap naturally DEPTH-1 -> 0. Fullness is determined solely by fifo_cnt.
- Full: fifo_cnt==DEPTH. Ready drops. A beat is never dropped or overwritten, including a partially packed word (lane holds its value).
- Underflow:
  - fifo_rd with fifo_cnt==0 has no effect on pointers or count.
  - It sets underflow=1, which holds until clear or reset.
- clear (synchronous, highest priority over push and pop in that cycle):
  - Pointers, count, lane, partial word and underflow all go to 0.
  - Any beat presented that cycle is not accepted (ready is low).

Test Plan:
- IW=16, WB_DW=32. Accept 0x1111 then 0x2222 on consecutive cycles -> one cycle after the second accept, fifo_cnt=1 and fifo_d=0x22221111. No earlier change to fifo_cnt.
- Accept 0xABCD with stream_s_last_i=1 at lane 0 -> fifo_d=0x0000ABCD, fifo_cnt=1. Next beats 0x0001, 0x0002 -> second word 0x00020001.
- FIFO_AW=4. Stream 32 beats with no pops -> fifo_cnt=16 and stream_s_ready_o=0. Hold valid with 0x5555 and assert fifo_rd one cycle -> fifo_cnt=15 next cycle, ready=1, 0x5555 accepted, and popped data equals the first word written.
- With fifo_cnt=5, complete a word push on the same edge as fifo_rd -> fifo_cnt stays 5. Draining all words returns them in write order across pointer wrap (write 40 words total with interleaved pops, check sequence).
- With fifo_cnt=0, pulse fifo_rd -> fifo_cnt stays 0 and underflow=1 persists. Pulse clear -> underflow=0.
- Accept one beat (lane 1 pending), then assert wb_rst_i asynchronously mid-cycle -> fifo_cnt=0 and ready=0 immediately. After release, 0x3333, 0x4444 pack to 0x44443333, proving the lane was reset.
